// File: rtl/tt_sel_ctrl.sv
// Design-select controller for tt_top: receives a serial design index on slow pad pins,
// range-checks it, commits it to si_sel and holds the newly selected design in reset.
//
// state | meaning
// IDLE  | waiting for the first bit of a frame
// SHIFT | collecting bits; a latch edge commits or rejects the frame
// RST   | des_rst asserted for RST_CYCLES clocks, all pad edges ignored
module tt_sel_ctrl #(
  parameter int SEL_W       = 10,
  parameter int NUM_DESIGNS = 500,
  parameter int RST_CYCLES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ctrl_sclk,
  input  logic             ctrl_sdata,
  input  logic             ctrl_latch,
  output logic [SEL_W-1:0] si_sel,
  output logic             sel_valid,
  output logic             sel_err,
  output logic             des_rst,
  output logic             busy
);

  localparam int CNT_W = $clog2(SEL_W + 2);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(SEL_W + 1);
  localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(RST_CYCLES);
  localparam logic [SEL_W:0]   NUM_LIM  = (SEL_W + 1)'(NUM_DESIGNS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_RST
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, latch_sync;
  logic sclk_q, latch_q;
  logic sclk_rise, latch_rise, sdata_s;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RC_W-1:0]   rcnt, rcnt_nxt;
  logic [SEL_W-1:0]  shreg, shreg_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              valid_nxt, err_nxt, des_rst_nxt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      latch_sync <= '0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], ctrl_sclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], ctrl_sdata};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], ctrl_latch};
      sclk_q     <= sclk_sync[SYNC_STAGES-1];
      latch_q    <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_q;
  assign sdata_s    = sdata_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_RST;
      cnt       <= '0;
      rcnt      <= RC_INIT;
      shreg     <= '0;
      si_sel    <= '0;
      sel_valid <= 1'b0;
      sel_err   <= 1'b0;
      des_rst   <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rcnt      <= rcnt_nxt;
      shreg     <= shreg_nxt;
      si_sel    <= sel_nxt;
      sel_valid <= valid_nxt;
      sel_err   <= err_nxt;
      des_rst   <= des_rst_nxt;
      busy      <= des_rst_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rcnt_nxt    = rcnt;
    shreg_nxt   = shreg;
    sel_nxt     = si_sel;
    valid_nxt   = sel_valid;
    err_nxt     = sel_err;
    des_rst_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        // a latch with no bits is an empty frame; a simultaneous bit is dropped
        if (latch_rise) begin
          err_nxt = 1'b1;
        end else if (sclk_rise) begin
          shreg_nxt = {shreg[SEL_W-2:0], sdata_s};
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (latch_rise) begin
          shreg_nxt = '0;
          cnt_nxt   = '0;
          if (cnt == CNT_FULL && {1'b0, shreg} < NUM_LIM) begin
            sel_nxt   = shreg;
            valid_nxt = 1'b1;
            err_nxt   = 1'b0;
            rcnt_nxt  = RC_INIT;
            state_nxt = ST_RST;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (sclk_rise) begin
          shreg_nxt = {shreg[SEL_W-2:0], sdata_s};
          if (cnt != CNT_OVF) cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RST: begin
        if (rcnt <= RC_W'(1)) state_nxt = ST_IDLE;
        else rcnt_nxt = rcnt - RC_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
    des_rst_nxt = (state_nxt == ST_RST);
  end

endmodule
